// File: rtl/alu_stim_seq.sv
// Reads prbs16 words, packs them into ALU test vectors, issues them over valid/ready,
// and folds each ALU result into a 16-bit MISR signature.
module alu_stim_seq #(
  parameter int unsigned NUM_VEC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] prbsSeq,
  output logic        shiftEn,
  output logic [7:0]  aluA,
  output logic [7:0]  aluB,
  output logic [3:0]  aluOp,
  output logic        aluValid,
  input  logic        aluReady,
  input  logic        resValid,
  input  logic [15:0] resData,
  output logic        busy,
  output logic        done,
  output logic [15:0] vecCount,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_AB,
    FETCH_OP,
    ISSUE,
    WAIT_RES,
    FINISH
  } state_t;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VEC);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] vecNext;
  logic        sigFb;

  assign vecNext = vecCount + 16'd1;
  assign sigFb   = signature[15] ^ signature[13] ^ signature[12] ^ signature[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      aluA      <= '0;
      aluB      <= '0;
      aluOp     <= '0;
      vecCount  <= '0;
      signature <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            vecCount  <= '0;
            signature <= '0;
          end
        end
        FETCH_AB: begin
          aluA <= prbsSeq[7:0];
          aluB <= prbsSeq[15:8];
        end
        FETCH_OP: begin
          aluOp <= prbsSeq[3:0];
        end
        WAIT_RES: begin
          if (resValid) begin
            vecCount  <= vecNext;
            signature <= {signature[14:0], sigFb} ^ resData;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    shiftEn   = 1'b0;
    aluValid  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH_AB;
      end
      FETCH_AB: begin
        shiftEn   = 1'b1;
        state_nxt = FETCH_OP;
      end
      FETCH_OP: begin
        shiftEn   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        aluValid = 1'b1;
        if (aluReady) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (resValid) state_nxt = (vecNext == LAST_VEC) ? FINISH : FETCH_AB;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_stim_seq.sv
// Directed bench for alu_stim_seq: one NUM_VEC=1 instance and one NUM_VEC=4 instance,
// each fed by its own behavioural prbs16 (x^16+x^14+x^13+x^11, seed FFFF on rst).
module tb_alu_stim_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic        aluReady, resValid;
  logic [15:0] resData;
  logic [15:0] prbs1, prbs4;

  logic        shiftEn1, aluValid1, busy1, done1;
  logic [7:0]  aluA1, aluB1;
  logic [3:0]  aluOp1;
  logic [15:0] vecCount1, signature1;

  logic        shiftEn4, aluValid4, busy4, done4;
  logic [7:0]  aluA4, aluB4;
  logic [3:0]  aluOp4;
  logic [15:0] vecCount4, signature4;

  int nTests = 0;
  int nFail  = 0;
  int shCnt1 = 0, shCnt4 = 0, doneCnt1 = 0, doneCnt4 = 0;

  always #5 clk = ~clk;

  alu_stim_seq #(.NUM_VEC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .prbsSeq(prbs1), .shiftEn(shiftEn1),
    .aluA(aluA1), .aluB(aluB1), .aluOp(aluOp1), .aluValid(aluValid1), .aluReady(aluReady),
    .resValid(resValid), .resData(resData), .busy(busy1), .done(done1),
    .vecCount(vecCount1), .signature(signature1)
  );

  alu_stim_seq #(.NUM_VEC(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .prbsSeq(prbs4), .shiftEn(shiftEn4),
    .aluA(aluA4), .aluB(aluB4), .aluOp(aluOp4), .aluValid(aluValid4), .aluReady(aluReady),
    .resValid(resValid), .resData(resData), .busy(busy4), .done(done4),
    .vecCount(vecCount4), .signature(signature4)
  );

  always @(posedge clk) begin
    if (rst) prbs1 <= 16'hFFFF;
    else if (shiftEn1) prbs1 <= {prbs1[14:0], prbs1[15] ^ prbs1[13] ^ prbs1[12] ^ prbs1[10]};
    if (rst) prbs4 <= 16'hFFFF;
    else if (shiftEn4) prbs4 <= {prbs4[14:0], prbs4[15] ^ prbs4[13] ^ prbs4[12] ^ prbs4[10]};
    if (shiftEn1) shCnt1 <= shCnt1 + 1;
    if (shiftEn4) shCnt4 <= shCnt4 + 1;
    if (done1) doneCnt1 <= doneCnt1 + 1;
    if (done4) doneCnt4 <= doneCnt4 + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int sh0, dn0, k;
  logic [7:0] a4v2, b4v2;
  logic [15:0] rd4 [4];

  initial begin
    rd4[0] = 16'h3400; rd4[1] = 16'h1000; rd4[2] = 16'h00FF; rd4[3] = 16'hA5A5;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    aluReady = 1'b0; resValid = 1'b0; resData = '0;

    // T1 reset
    step(); step();
    chk("t1_aluA", 16'(aluA1), 16'h0);
    chk("t1_aluB", 16'(aluB1), 16'h0);
    chk("t1_aluOp", 16'(aluOp1), 16'h0);
    chk("t1_vecCount", vecCount1, 16'h0);
    chk("t1_signature", signature1, 16'h0);
    chk("t1_shiftEn", 16'(shiftEn1), 16'h0);
    chk("t1_aluValid", 16'(aluValid1), 16'h0);
    chk("t1_busy", 16'(busy1), 16'h0);
    chk("t1_done", 16'(done1), 16'h0);
    chk("t1_busy4", 16'(busy4), 16'h0);
    rst = 1'b0;

    // T2 single vector, result two cycles after accept
    step();
    sh0 = shCnt1; dn0 = doneCnt1;
    aluReady = 1'b1; start1 = 1'b1;
    step(); start1 = 1'b0;
    chk("t2_fab_shift", 16'(shiftEn1), 16'h1);
    chk("t2_fab_busy", 16'(busy1), 16'h1);
    chk("t2_fab_valid", 16'(aluValid1), 16'h0);
    step();
    chk("t2_fop_shift", 16'(shiftEn1), 16'h1);
    chk("t2_fop_valid", 16'(aluValid1), 16'h0);
    step();
    chk("t2_issue_valid", 16'(aluValid1), 16'h1);
    chk("t2_issue_shift", 16'(shiftEn1), 16'h0);
    chk("t2_aluA", 16'(aluA1), 16'h00FF);
    chk("t2_aluB", 16'(aluB1), 16'h00FF);
    chk("t2_aluOp", 16'(aluOp1), 16'h000E);
    step(); aluReady = 1'b0;
    chk("t2_wait_valid", 16'(aluValid1), 16'h0);
    step(); resValid = 1'b1; resData = 16'h1234;
    step(); resValid = 1'b0;
    chk("t2_done", 16'(done1), 16'h1);
    chk("t2_signature", signature1, 16'h1234);
    chk("t2_vecCount", vecCount1, 16'h0001);
    step();
    chk("t2_done_low", 16'(done1), 16'h0);
    chk("t2_idle_busy", 16'(busy1), 16'h0);
    chk("t2_shift_cycles", 16'(shCnt1 - sh0), 16'd2);
    chk("t2_done_pulses", 16'(doneCnt1 - dn0), 16'd1);

    // T3/T4 ready stall, start and resValid while busy ignored
    sh0 = shCnt1;
    start1 = 1'b1;
    step(); start1 = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_hold", 16'(aluValid1), 16'h1);
      chk("t3_shift_low", 16'(shiftEn1), 16'h0);
      chk("t3_aluA_stable", 16'(aluA1), 16'h00FC);
      chk("t3_aluB_stable", 16'(aluB1), 16'h00FF);
      chk("t3_aluOp_stable", 16'(aluOp1), 16'h0008);
      if (i == 1) begin start1 = 1'b1; resValid = 1'b1; resData = 16'hFFFF; end
      if (i == 2) begin start1 = 1'b0; resValid = 1'b0; end
      if (i == 4) aluReady = 1'b1;
      step();
    end
    aluReady = 1'b0;
    chk("t3_advanced", 16'(aluValid1), 16'h0);
    chk("t3_wait_busy", 16'(busy1), 16'h1);
    chk("t4_sig_issue_ignored", signature1, 16'h0);
    chk("t4_cnt_issue_ignored", vecCount1, 16'h0);
    chk("t3_shift_cycles", 16'(shCnt1 - sh0), 16'd2);
    resValid = 1'b1; resData = 16'h0F0F;
    step(); resValid = 1'b0;
    chk("t3_done", 16'(done1), 16'h1);
    chk("t3_signature", signature1, 16'h0F0F);
    step();
    resValid = 1'b1; resData = 16'h5555;
    step(); resValid = 1'b0;
    step();
    chk("t4_sig_idle_ignored", signature1, 16'h0F0F);
    chk("t4_cnt_idle_ignored", vecCount1, 16'h0001);
    chk("t4_idle_busy", 16'(busy1), 16'h0);

    // T5 reset during WAIT_RES
    dn0 = doneCnt1;
    aluReady = 1'b1; start1 = 1'b1;
    step(); start1 = 1'b0;
    step(); step();
    chk("t5_issue_valid", 16'(aluValid1), 16'h1);
    step(); aluReady = 1'b0;
    chk("t5_in_wait", 16'(busy1), 16'h1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("t5_busy", 16'(busy1), 16'h0);
    chk("t5_done", 16'(done1), 16'h0);
    chk("t5_signature", signature1, 16'h0);
    chk("t5_vecCount", vecCount1, 16'h0);
    chk("t5_aluA", 16'(aluA1), 16'h0);
    step();
    chk("t5_no_done_pulse", 16'(doneCnt1 - dn0), 16'd0);

    // T6 four vectors, results returned the cycle after each accept
    sh0 = shCnt4; dn0 = doneCnt4;
    aluReady = 1'b1; start4 = 1'b1;
    step(); start4 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      k = 0;
      while (!aluValid4 && k < 20) begin step(); k++; end
      chk("t6_valid_seen", 16'(aluValid4), 16'h1);
      if (v == 1) begin a4v2 = aluA4; b4v2 = aluB4; end
      step();
      resValid = 1'b1; resData = rd4[v];
      step(); resValid = 1'b0;
    end
    chk("t6_done", 16'(done4), 16'h1);
    chk("t6_vecCount", vecCount4, 16'd4);
    chk("t6_signature", signature4, 16'h445E);
    chk("t6_vec2_aluA", 16'(a4v2), 16'h00FC);
    chk("t6_vec2_aluB", 16'(b4v2), 16'h00FF);
    step();
    chk("t6_shift_cycles", 16'(shCnt4 - sh0), 16'd8);
    chk("t6_done_pulses", 16'(doneCnt4 - dn0), 16'd1);
    chk("t6_idle_busy", 16'(busy4), 16'h0);
    chk("t6_u1_idle", 16'(busy1), 16'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
